// File: rtl/mem_port_fsm.sv
// 8088 minimum-mode bus slave: latches the address on ALE, runs read and write cycles from RD/WR, serves a byte memory.
// Read data reaches AD one clk after RD is sampled low. There is no backpressure: the CPU owns all strobe timing.
module mem_port_fsm #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ALE,
    input  logic              RD,
    input  logic              WR,
    input  logic              CS,
    input  logic [11:0]       A,
    inout  wire  [DATA_W-1:0] AD
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   cap_q;
    logic [DATA_W-1:0]   cap_d;
    logic [DATA_W-1:0]   rdat_q;
    logic [DATA_W-1:0]   rdat_d;
    logic                mem_we;
    logic [11+DATA_W:0]  bus_addr;
    logic [DATA_W-1:0]   init_pat;
    logic [DATA_W-1:0]   mem_rd;
    logic                ad_oe;

    // Storage powers up zeroed; bytes are kept XORed with the low address
    // byte so an untouched location reads back as its own index.
    logic [DATA_W-1:0]   mem [DEPTH];

    assign bus_addr = {A, AD};
    assign init_pat = DATA_W'(addr_q);
    assign mem_rd   = mem[addr_q] ^ init_pat;

    // Output enable follows RD combinationally so AD lets go as RD rises.
    assign ad_oe = (state_q == READ) && !RD;
    assign AD    = ad_oe ? rdat_q : {DATA_W{1'bz}};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cap_d   = cap_q;
        rdat_d  = rdat_q;
        mem_we  = 1'b0;
        if (ALE) begin
            addr_d  = bus_addr[ADDR_W-1:0];
            state_d = ADDR;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ADDR: begin
                    if (CS && !RD && WR) begin
                        rdat_d  = mem_rd;
                        state_d = READ;
                    end else if (CS && !WR && RD) begin
                        cap_d   = AD;
                        state_d = WRITE;
                    end
                end
                READ: begin
                    if (RD) begin
                        state_d = IDLE;
                    end
                end
                WRITE: begin
                    if (WR) begin
                        mem_we  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cap_d = AD;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cap_q   <= '0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cap_q   <= cap_d;
            rdat_q  <= rdat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= cap_q ^ init_pat;
        end
    end

endmodule

// File: tb/tb_mem_port_fsm.sv
// Bench for mem_port_fsm: table of bus cycles with a read-data scoreboard, plus reset/abort/illegal-strobe sequences.
// While the DUT must stay off AD the bench drives a probe value there, so any stray drive corrupts the value read back.
module tb_mem_port_fsm;
    logic        clk;
    logic        reset;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        CS;
    logic [11:0] A;
    logic        drv_en;
    logic [7:0]  drv_dat;
    wire  [7:0]  ad;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_q [$];
    logic [7:0]  cur_exp;

    typedef struct {
        bit         wr;
        bit         cs;
        logic [19:0] addr;
        logic [7:0]  dat;
    } vec_t;

    vec_t vecs [$];

    assign ad = drv_en ? drv_dat : 8'hzz;

    mem_port_fsm #(.ADDR_W(20), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .ALE   (ALE),
        .RD    (RD),
        .WR    (WR),
        .CS    (CS),
        .A     (A),
        .AD    (ad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string nm, input logic [7:0] got, input logic [7:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: ad=%02h required %02h", nm, got, req);
        end
    endtask

    // Pops the next expected read byte when asked, then compares the bus to it.
    task automatic sb_check(input string nm, input bit pop);
        if (pop) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s: scoreboard empty, ad=%02h", nm, ad);
                return;
            end
            cur_exp = exp_q.pop_front();
        end
        check8(nm, ad, cur_exp);
    endtask

    task automatic addr_phase(input logic [19:0] addr, input logic cs);
        ALE     = 1'b1;
        A       = addr[19:8];
        drv_en  = 1'b1;
        drv_dat = addr[7:0];
        CS      = cs;
        RD      = 1'b1;
        WR      = 1'b1;
        tick();
        ALE     = 1'b0;
    endtask

    task automatic bus_write(input logic [19:0] addr, input logic [7:0] dat, input logic cs);
        addr_phase(addr, cs);
        WR      = 1'b0;
        drv_dat = dat;
        tick();
        tick();
        WR      = 1'b1;
        drv_dat = ~dat;
        tick();
        drv_dat = 8'h00;
    endtask

    task automatic bus_read(input logic [19:0] addr, input logic cs, input logic [7:0] dat, input string nm);
        addr_phase(addr, cs);
        RD      = 1'b0;
        drv_dat = 8'h00;
        #1;
        check8({nm, " early"}, ad, 8'h00);
        if (cs) begin
            exp_q.push_back(dat);
            drv_en = 1'b0;
            tick();
            sb_check({nm, " data1"}, 1'b1);
            tick();
            sb_check({nm, " data2"}, 1'b0);
        end else begin
            tick();
            check8({nm, " nodrv1"}, ad, 8'h00);
            tick();
            check8({nm, " nodrv2"}, ad, 8'h00);
        end
        RD      = 1'b1;
        drv_en  = 1'b1;
        drv_dat = 8'h00;
        #1;
        check8({nm, " release"}, ad, 8'h00);
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cur_exp  = 8'h00;

        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h12345, dat: 8'h45});
        vecs.push_back('{wr: 1'b1, cs: 1'b1, addr: 20'h00100, dat: 8'hA5});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h00100, dat: 8'hA5});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h00101, dat: 8'h01});
        vecs.push_back('{wr: 1'b1, cs: 1'b0, addr: 20'h00200, dat: 8'h3C});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h00200, dat: 8'h00});
        vecs.push_back('{wr: 1'b0, cs: 1'b0, addr: 20'h00200, dat: 8'h00});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'hABCDE, dat: 8'hDE});
        vecs.push_back('{wr: 1'b1, cs: 1'b1, addr: 20'h80000, dat: 8'h5A});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h80000, dat: 8'h5A});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h00000, dat: 8'h00});
        vecs.push_back('{wr: 1'b1, cs: 1'b1, addr: 20'h0AB55, dat: 8'hC3});
        vecs.push_back('{wr: 1'b1, cs: 1'b1, addr: 20'h00100, dat: 8'h3C});
        vecs.push_back('{wr: 1'b0, cs: 1'b1, addr: 20'h00100, dat: 8'h3C});

        // Reset held with ALE and RD active: the DUT must stay off the bus.
        reset   = 1'b0;
        ALE     = 1'b1;
        RD      = 1'b0;
        WR      = 1'b1;
        CS      = 1'b1;
        A       = 12'h123;
        drv_en  = 1'b1;
        drv_dat = 8'h45;
        for (int i = 0; i < 3; i++) begin
            tick();
            check8($sformatf("reset hold %0d", i), ad, 8'h45);
        end
        ALE     = 1'b0;
        drv_dat = 8'h00;
        tick();
        reset   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check8($sformatf("post reset idle %0d", i), ad, 8'h00);
        end
        RD = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].dat, vecs[i].cs);
            end else begin
                bus_read(vecs[i].addr, vecs[i].cs, vecs[i].dat, $sformatf("vec%0d", i));
            end
        end

        // ALE mid-read: the DUT's own byte 0x55 forms the new low address, 0x0AB55.
        addr_phase(20'h00055, 1'b1);
        RD     = 1'b0;
        exp_q.push_back(8'h55);
        drv_en = 1'b0;
        tick();
        sb_check("abort first data", 1'b1);
        ALE    = 1'b1;
        A      = 12'h0AB;
        tick();
        ALE     = 1'b0;
        drv_en  = 1'b1;
        drv_dat = 8'h00;
        #1;
        check8("abort release", ad, 8'h00);
        exp_q.push_back(8'hC3);
        drv_en = 1'b0;
        tick();
        sb_check("abort new addr", 1'b1);
        RD      = 1'b1;
        drv_en  = 1'b1;
        drv_dat = 8'h00;
        #1;
        check8("abort end release", ad, 8'h00);
        tick();

        // RD and WR low together: no drive, no write.
        addr_phase(20'h004EE, 1'b1);
        RD      = 1'b0;
        WR      = 1'b0;
        drv_dat = 8'h11;
        for (int i = 0; i < 2; i++) begin
            tick();
            check8($sformatf("illegal nodrv %0d", i), ad, 8'h11);
        end
        RD = 1'b1;
        WR = 1'b1;
        tick();
        bus_read(20'h004EE, 1'b1, 8'hEE, "illegal mem");

        // Async reset in the middle of a read releases AD at once.
        addr_phase(20'h12345, 1'b1);
        RD     = 1'b0;
        exp_q.push_back(8'h45);
        drv_en = 1'b0;
        tick();
        sb_check("rst read data", 1'b1);
        #2;
        reset   = 1'b0;
        drv_en  = 1'b1;
        drv_dat = 8'h00;
        #1;
        check8("rst read release", ad, 8'h00);
        RD = 1'b1;
        tick();
        reset = 1'b1;
        tick();

        // Async reset in the middle of a write: the write is dropped.
        addr_phase(20'h00300, 1'b1);
        WR      = 1'b0;
        drv_dat = 8'h77;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check8("rst write nodrv", ad, 8'h77);
        WR      = 1'b1;
        drv_dat = 8'h88;
        tick();
        tick();
        reset = 1'b1;
        tick();
        bus_read(20'h00300, 1'b1, 8'h00, "rst write mem");

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
